// File: rtl/result_writeback.sv
// result_writeback: drains an NxN systolic-array result set into the unified
// buffer one row per write. Each lane is requantized with round-half-up,
// arithmetic right shift, optional ReLU and saturation to DATA_WIDTH.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      one-cycle job request, synchronous job cancel
//   base_addr         UB address of result row 0 (latched on start)
//   shift, relu_en    requantization controls (latched on start)
//   results_flat      N*N accumulators, element (r,c) at index r*N+c
//   result_valid      results_flat holds a complete result set
//   ub_wr_gnt         UB write port granted this cycle
//   ub_wr_en/addr/data  UB write request, address and requantized row
//   busy, done        job in progress, one-cycle completion pulse
//   sat_flag          sticky: a lane saturated in the current or last job
`timescale 1ns/1ps

`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module result_writeback #(
  parameter int unsigned N            = `ARRAY_SIZE,
  parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
  parameter int unsigned ACC_WIDTH    = `ACC_WIDTH,
  parameter int unsigned ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int unsigned BUFFER_WIDTH = `BUFFER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [4:0]                   shift,
  input  logic                         relu_en,
  input  logic [N*N*ACC_WIDTH-1:0]     results_flat,
  input  logic                         result_valid,
  input  logic                         ub_wr_gnt,
  output logic                         ub_wr_en,
  output logic [ADDR_WIDTH-1:0]        ub_wr_addr,
  output logic [BUFFER_WIDTH-1:0]      ub_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int unsigned ROW_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ROW_BITS = N * ACC_WIDTH;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2 ** (DATA_WIDTH-1)));

  typedef enum logic [1:0] {IDLE, WAIT_VALID, WRITE, DONE} state_t;

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [ROW_W-1:0]        row_next;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    row_sat;      // currently presented row saturates
  logic [ROW_BITS-1:0]     snap [N];
  logic [BUFFER_WIDTH:0]   cap_word;     // {sat, data} for row 0 of incoming results
  logic [BUFFER_WIDTH:0]   nxt_word;     // {sat, data} for snapshot row row+1

  // One lane: round-half-up, arithmetic shift, optional ReLU, saturate.
  // Result is {saturated, lane}.
  function automatic logic [DATA_WIDTH:0] requant_lane(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [4:0]           sh,
    input logic                 rl
  );
    logic signed [ACC_WIDTH:0] v;
    logic signed [ACC_WIDTH:0] rnd;
    rnd = (sh != 5'd0) ? $signed((ACC_WIDTH+1)'(1) << (sh - 5'd1)) : '0;
    v   = $signed({acc[ACC_WIDTH-1], acc}) + rnd;
    v   = v >>> sh;
    if (rl && (v < 0)) v = '0;
    if (v > SAT_MAX)      requant_lane = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    else if (v < SAT_MIN) requant_lane = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    else                  requant_lane = {1'b0, v[DATA_WIDTH-1:0]};
  endfunction

  // Whole row: packed lanes plus an OR of the per-lane saturation bits on top.
  function automatic logic [BUFFER_WIDTH:0] requant_row(
    input logic [ROW_BITS-1:0] accs,
    input logic [4:0]          sh,
    input logic                rl
  );
    logic [BUFFER_WIDTH-1:0] data;
    logic                    sat;
    logic [DATA_WIDTH:0]     lane;
    data = '0;
    sat  = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      lane = requant_lane(accs[c*ACC_WIDTH +: ACC_WIDTH], sh, rl);
      data[c*DATA_WIDTH +: DATA_WIDTH] = lane[DATA_WIDTH-1:0];
      sat = sat | lane[DATA_WIDTH];
    end
    requant_row = {sat, data};
  endfunction

  assign row_next = row + ROW_W'(1);

  // Requantize ahead of time so the write data is always a register.
  always_comb begin
    cap_word = requant_row(results_flat[ROW_BITS-1:0], shift_q, relu_q);
    nxt_word = requant_row(snap[row_next], shift_q, relu_q);
  end

  // Job FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      base_q     <= '0;
      row_sat    <= 1'b0;
      ub_wr_en   <= 1'b0;
      ub_wr_addr <= '0;
      ub_wr_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat_flag   <= 1'b0;
      for (int unsigned r = 0; r < N; r++) snap[r] <= '0;
    end else if (abort) begin
      state    <= IDLE;
      row      <= '0;
      ub_wr_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_q   <= base_addr;
            shift_q  <= shift;
            relu_q   <= relu_en;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          if (result_valid) begin
            for (int unsigned r = 0; r < N; r++)
              snap[r] <= results_flat[r*ROW_BITS +: ROW_BITS];
            row        <= '0;
            ub_wr_en   <= 1'b1;
            ub_wr_addr <= base_q;
            ub_wr_data <= cap_word[BUFFER_WIDTH-1:0];
            row_sat    <= cap_word[BUFFER_WIDTH];
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (ub_wr_en && ub_wr_gnt) begin
            if (row_sat) sat_flag <= 1'b1;
            if (row == ROW_W'(N-1)) begin
              row      <= '0;
              ub_wr_en <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              row        <= row_next;
              ub_wr_addr <= ub_wr_addr + ADDR_WIDTH'(1);
              ub_wr_data <= nxt_word[BUFFER_WIDTH-1:0];
              row_sat    <= nxt_word[BUFFER_WIDTH];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed, table-driven bench for result_writeback
// (N=4, DATA_WIDTH=8, ACC_WIDTH=32, ADDR_WIDTH=8).
`timescale 1ns/1ps

module tb_result_writeback;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [7:0]   base_addr;
  logic [4:0]   shift;
  logic         relu_en;
  logic [511:0] results_flat;
  logic         result_valid;
  logic         ub_wr_gnt;
  logic         ub_wr_en;
  logic [7:0]   ub_wr_addr;
  logic [31:0]  ub_wr_data;
  logic         busy;
  logic         done;
  logic         sat_flag;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  result_writeback #(
    .N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(8), .BUFFER_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .shift(shift), .relu_en(relu_en),
    .results_flat(results_flat), .result_valid(result_valid),
    .ub_wr_gnt(ub_wr_gnt), .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
    .ub_wr_data(ub_wr_data), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every accepted write and every done cycle.
  always @(posedge clk) begin
    if (rst_n && ub_wr_en && ub_wr_gnt) begin
      wr_addr_q.push_back(ub_wr_addr);
      wr_data_q.push_back(ub_wr_data);
    end
    if (rst_n && done) done_cnt = done_cnt + 1;
  end

  typedef struct {
    logic [31:0] acc;
    logic [4:0]  sh;
    logic        relu;
    logic [7:0]  lane;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] idx_flat();
    logic [511:0] f;
    f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        f[(r*4+c)*32 +: 32] = 32'(r*4 + c);
    return f;
  endfunction

  function automatic logic [511:0] const_flat(input logic [31:0] a);
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = a;
    return f;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, ub_wr_en, 0);
    chk({tag, "_addr"}, ub_wr_addr, 0);
    chk({tag, "_data"}, ub_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sat"}, sat_flag, 0);
  endtask

  // Start a job and capture results on the first WAIT_VALID cycle.
  // Returns #1 after the capture edge, with row 0 presented.
  task automatic start_and_capture(input logic [7:0] b, input logic [4:0] sh,
                                   input logic rl, input logic [511:0] flat);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt  = 0;
    base_addr = b;
    shift     = sh;
    relu_en   = rl;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 8'hAA;         // latched copies must be used from here on
    shift     = 5'd7;
    relu_en   = ~rl;
    chk("busy_wait_valid", busy, 1);
    results_flat = flat;
    result_valid = 1'b1;
    @(posedge clk); #1;
    results_flat = '1;         // snapshot must ignore later input changes
  endtask

  // Wait (bounded) for done; cycle 1 is the first cycle after capture.
  task automatic wait_done(output int lat, output int first);
    lat   = -1;
    first = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (ub_wr_en && first < 0) first = c;
      if (done) lat = c;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("done_seen", done, 1);
    result_valid = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] b, input logic [4:0] sh, input logic rl,
                         input logic [511:0] flat, output int lat, output int first);
    start_and_capture(b, sh, rl, flat);
    wait_done(lat, first);
  endtask

  int lat;
  int first;

  initial begin
    vecs[0]  = '{32'd1000,        5'd2,  1'b0, 8'h7F, 1'b1};
    vecs[1]  = '{32'(-7),         5'd1,  1'b0, 8'hFD, 1'b0};
    vecs[2]  = '{32'(-7),         5'd1,  1'b1, 8'h00, 1'b0};
    vecs[3]  = '{32'd255,         5'd1,  1'b0, 8'h7F, 1'b1};
    vecs[4]  = '{32'd127,         5'd0,  1'b0, 8'h7F, 1'b0};
    vecs[5]  = '{32'(-300),       5'd0,  1'b0, 8'h80, 1'b1};
    vecs[6]  = '{32'(-128),       5'd0,  1'b0, 8'h80, 1'b0};
    vecs[7]  = '{32'd5,           5'd1,  1'b0, 8'h03, 1'b0};
    vecs[8]  = '{32'(-5),         5'd1,  1'b0, 8'hFE, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF,   5'd31, 1'b0, 8'h01, 1'b0};
    vecs[10] = '{32'h8000_0000,   5'd31, 1'b0, 8'hFF, 1'b0};
    vecs[11] = '{32'(-300),       5'd0,  1'b1, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; shift = '0;
    relu_en = 1'b0; results_flat = '0; result_valid = 1'b0; ub_wr_gnt = 1'b1;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic job: index pattern, shift 0, base 0x10.
    run_job(8'h10, 5'd0, 1'b0, idx_flat(), lat, first);
    chk("first_wr_latency", first, 1);
    chk("done_latency", lat, 5);
    chk("basic_wr_count", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
      chk($sformatf("basic_addr%0d", i), wr_addr_q[i], 8'h10 + 8'(i));
    if (wr_data_q.size() == 4) begin
      chk("basic_row0", wr_data_q[0], 32'h03020100);
      chk("basic_row3", wr_data_q[3], 32'h0F0E0D0C);
    end
    chk("basic_sat", sat_flag, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt, 1);

    // Requantization table.
    for (int v = 0; v < 12; v++) begin
      run_job(8'h00, vecs[v].sh, vecs[v].relu, const_flat(vecs[v].acc), lat, first);
      chk($sformatf("vec%0d_count", v), wr_data_q.size(), 4);
      if (wr_data_q.size() == 4) begin
        chk($sformatf("vec%0d_row0", v), wr_data_q[0], {4{vecs[v].lane}});
        chk($sformatf("vec%0d_row3", v), wr_data_q[3], {4{vecs[v].lane}});
      end
      chk($sformatf("vec%0d_sat", v), sat_flag, vecs[v].sat);
      @(posedge clk); #1;
    end

    // Grant held low for 3 cycles on row 1.
    start_and_capture(8'h10, 5'd0, 1'b0, idx_flat());
    @(posedge clk); #1;
    ub_wr_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ub_wr_gnt = 1'b1;
      chk($sformatf("stall_addr%0d", i), ub_wr_addr, 8'h11);
      chk($sformatf("stall_data%0d", i), ub_wr_data, 32'h07060504);
      chk($sformatf("stall_en%0d", i), ub_wr_en, 1);
      @(posedge clk); #1;
    end
    wait_done(lat, first);
    chk("stall_count", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk($sformatf("stall_q_addr%0d", i), wr_addr_q[i], 8'h10 + 8'(i));
      chk($sformatf("stall_q_data%0d", i), wr_data_q[i],
          {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    end
    @(posedge clk); #1;

    // Address wrap.
    run_job(8'hFE, 5'd0, 1'b0, idx_flat(), lat, first);
    chk("wrap_count", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) begin
      chk("wrap_a0", wr_addr_q[0], 8'hFE);
      chk("wrap_a1", wr_addr_q[1], 8'hFF);
      chk("wrap_a2", wr_addr_q[2], 8'h00);
      chk("wrap_a3", wr_addr_q[3], 8'h01);
    end
    @(posedge clk); #1;

    // Start ignored during WRITE, then abort on row 2.
    start_and_capture(8'h40, 5'd0, 1'b0, idx_flat());
    start = 1'b1;
    base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_start_addr1", ub_wr_addr, 8'h41);
    @(posedge clk); #1;
    chk("ign_start_addr2", ub_wr_addr, 8'h42);
    abort = 1'b1;
    ub_wr_gnt = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    ub_wr_gnt = 1'b1;
    result_valid = 1'b0;
    chk("abort_wr_en", ub_wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_wr_count", wr_addr_q.size(), 2);
    chk("abort_idle_busy", busy, 0);

    // Asynchronous reset in the middle of WRITE.
    start_and_capture(8'h30, 5'd2, 1'b0, const_flat(32'd1000));
    @(posedge clk); #1;
    chk("pre_reset_sat", sat_flag, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    result_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8'h50, 5'd0, 1'b0, idx_flat(), lat, first);
    chk("post_reset_latency", lat, 5);
    chk("post_reset_count", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) begin
      chk("post_reset_a0", wr_addr_q[0], 8'h50);
      chk("post_reset_row3", wr_data_q[3], 32'h0F0E0D0C);
    end
    @(posedge clk); #1;
    chk("post_reset_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
